// File: rtl/flash_cmd_pkg.sv
// Shared definitions for the MCU command front-end: frame constants,
// FSM state encodings and the layout of the issued 32-bit command word.
// Imported by flash_cmd_assembler and its bench.
package flash_cmd_pkg;

    // Frame: SYNC, CMD, PARAM, DHI, DLO, CHK
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         FRAME_LEN     = 6;
    localparam int         BODY_LEN      = 4;

    // FSM state encodings
    typedef logic [1:0] state_t;
    localparam state_t S_SYNC = 2'd0;
    localparam state_t S_BODY = 2'd1;
    localparam state_t S_CHK  = 2'd2;

    // Command word bit slices
    localparam int CMD_MSB   = 31;
    localparam int CMD_LSB   = 24;
    localparam int PARAM_MSB = 23;
    localparam int PARAM_LSB = 16;
    localparam int DATA_MSB  = 15;
    localparam int DATA_LSB  = 0;

    typedef struct packed {
        logic [7:0]  opcode;  // [31:24]
        logic [7:0]  param;   // [23:16]
        logic [15:0] data;    // [15:0]
    } cmd_word_t;

endpackage

// File: rtl/flash_cmd_timeout.sv
// Idle counter: counts cycles while run=1, cleared by clr or !run; expire
// flags the cycle the count sits at TIMEOUT_CYC-1 with no clear.
// Latency: expire is combinational from the count register; no backpressure.
// Ports: clk, rst (async, active-high), clr, run in; expire out.
module flash_cmd_timeout
    import flash_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 24000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expire
);

    localparam int            CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || !run) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    // A byte in the expiry cycle (clr) suppresses the timeout.
    assign expire = run && !clr && (cnt == LAST);

endmodule

// File: rtl/flash_cmd_assembler.sv
// Frames the MCU byte stream (SYNC,CMD,PARAM,DHI,DLO,CHK), checks the XOR
// checksum and issues cmd/start_trs one cycle after the CHK byte; no input
// backpressure - frames arriving while busy are dropped with busy_reject.
// Ports: clk, rst, rx_data/rx_valid, cmd_done in; cmd, start_trs, cmd_busy,
// frame_err, timeout_err, busy_reject, err_cnt out (all registered).
module flash_cmd_assembler
    import flash_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = 24000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        cmd_done,
    output logic [31:0] cmd,
    output logic        start_trs,
    output logic        cmd_busy,
    output logic        frame_err,
    output logic        timeout_err,
    output logic        busy_reject,
    output logic [7:0]  err_cnt
);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] asm_q, asm_d;
    logic [7:0]  xor_q, xor_d;

    logic issue, err_frame, err_busy, err_to;
    logic tmo_expire;

    flash_cmd_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (rx_valid),
        .run    (state_q != S_SYNC),
        .expire (tmo_expire)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        xor_d     = xor_q;
        issue     = 1'b0;
        err_frame = 1'b0;
        err_busy  = 1'b0;
        err_to    = tmo_expire;

        case (state_q)
            S_SYNC: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = S_BODY;
                    idx_d   = 2'd0;
                    xor_d   = 8'd0;
                end
            end
            S_BODY: begin
                // SYNC_BYTE here is plain payload.
                if (rx_valid) begin
                    asm_d = {asm_q[23:0], rx_data};
                    xor_d = xor_q ^ rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'(BODY_LEN - 1)) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (rx_valid) begin
                    state_d = S_SYNC;
                    if (rx_data != xor_q) begin
                        err_frame = 1'b1;
                    end else if (!cmd_busy || cmd_done) begin
                        // A completion landing with the CHK byte frees the slot.
                        issue = 1'b1;
                    end else begin
                        err_busy = 1'b1;
                    end
                end
            end
            default: state_d = S_SYNC;
        endcase

        // expire is never set together with rx_valid, so it cannot collide
        // with a completed frame.
        if (tmo_expire) begin
            state_d = S_SYNC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_SYNC;
            idx_q       <= 2'd0;
            asm_q       <= 32'd0;
            xor_q       <= 8'd0;
            cmd         <= 32'd0;
            start_trs   <= 1'b0;
            cmd_busy    <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            busy_reject <= 1'b0;
            err_cnt     <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            xor_q       <= xor_d;
            start_trs   <= issue;
            frame_err   <= err_frame;
            timeout_err <= err_to;
            busy_reject <= err_busy;
            if (issue) begin
                cmd <= asm_q;
            end
            // Issue wins over a same-cycle completion.
            if (issue) begin
                cmd_busy <= 1'b1;
            end else if (cmd_done) begin
                cmd_busy <= 1'b0;
            end
            if ((err_frame || err_busy || err_to) && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_flash_cmd_assembler.sv
// Directed bench for flash_cmd_assembler: drives bytes on the falling edge,
// samples outputs on the falling edge after the capturing rising edge.
// No backpressure on the DUT input; all expected values are hand-computed.
module tb_flash_cmd_assembler;
    import flash_cmd_pkg::*;

    localparam int         TO   = 20;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        cmd_done;
    logic [31:0] cmd;
    logic        start_trs;
    logic        cmd_busy;
    logic        frame_err;
    logic        timeout_err;
    logic        busy_reject;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    flash_cmd_assembler #(
        .SYNC_BYTE   (SYNC),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .cmd_done    (cmd_done),
        .cmd         (cmd),
        .start_trs   (start_trs),
        .cmd_busy    (cmd_busy),
        .frame_err   (frame_err),
        .timeout_err (timeout_err),
        .busy_reject (busy_reject),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        rx_valid = 1'b0;
        cmd_done = 1'b0;
    endtask

    // Sends a full frame back to back, optionally with cmd_done alongside
    // the CHK byte, then steps once so the CHK effects are visible.
    task automatic send_frame(input logic [7:0] c, input logic [7:0] p,
                              input logic [7:0] dh, input logic [7:0] dl,
                              input logic [7:0] k, input logic done_chk);
        drive(SYNC);
        drive(c);
        drive(p);
        drive(dh);
        drive(dl);
        @(negedge clk);
        rx_data  = k;
        rx_valid = 1'b1;
        cmd_done = done_chk;
        step();
    endtask

    task automatic pulse_done();
        @(negedge clk);
        rx_valid = 1'b0;
        cmd_done = 1'b1;
        step();
    endtask

    // Bad checksum (01^02^03^04 = 04, sent FF), no gap after CHK.
    task automatic bad_frame();
        drive(SYNC); drive(8'h01); drive(8'h02); drive(8'h03); drive(8'h04); drive(8'hFF);
    endtask

    cmd_word_t exp_w;

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        cmd_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd", cmd, 32'h0);
        check("rst_busy", {31'd0, cmd_busy}, 32'd0);
        rst = 1'b0;
        step();
        check("rst_start", {31'd0, start_trs}, 32'd0);
        check("rst_errs", {29'd0, frame_err, timeout_err, busy_reject}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);

        // Good frame
        send_frame(8'h02, 8'h00, 8'h12, 8'h34, 8'h24, 1'b0);
        exp_w = '{opcode: 8'h02, param: 8'h00, data: 16'h1234};
        check("good_cmd", cmd, exp_w);
        check("good_start", {31'd0, start_trs}, 32'd1);
        check("good_busy", {31'd0, cmd_busy}, 32'd1);
        step();
        check("good_start_1cyc", {31'd0, start_trs}, 32'd0);
        check("good_busy_hold", {31'd0, cmd_busy}, 32'd1);

        // Bad checksum
        send_frame(8'h02, 8'h00, 8'h12, 8'h34, 8'h25, 1'b0);
        check("bad_frame_err", {31'd0, frame_err}, 32'd1);
        check("bad_err_cnt", {24'd0, err_cnt}, 32'd1);
        check("bad_cmd", cmd, 32'h0200_1234);
        check("bad_start", {31'd0, start_trs}, 32'd0);
        step();
        check("bad_frame_err_1cyc", {31'd0, frame_err}, 32'd0);

        // Good frame while busy (03^11^22^33 = 03)
        send_frame(8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 1'b0);
        check("rej_pulse", {31'd0, busy_reject}, 32'd1);
        check("rej_cmd", cmd, 32'h0200_1234);
        check("rej_start", {31'd0, start_trs}, 32'd0);
        check("rej_err_cnt", {24'd0, err_cnt}, 32'd2);

        // cmd_done with the CHK byte (04^05^06^07 = 00)
        send_frame(8'h04, 8'h05, 8'h06, 8'h07, 8'h00, 1'b1);
        check("done_chk_start", {31'd0, start_trs}, 32'd1);
        check("done_chk_cmd", cmd, 32'h0405_0607);
        check("done_chk_busy", {31'd0, cmd_busy}, 32'd1);
        check("done_chk_no_rej", {31'd0, busy_reject}, 32'd0);

        pulse_done();
        check("done_clears_busy", {31'd0, cmd_busy}, 32'd0);
        pulse_done();
        check("idle_done_busy", {31'd0, cmd_busy}, 32'd0);
        check("idle_done_err_cnt", {24'd0, err_cnt}, 32'd2);

        // Timeout after A5 02
        drive(SYNC);
        drive(8'h02);
        repeat (TO) step();
        check("to_not_early", {31'd0, timeout_err}, 32'd0);
        step();
        check("to_pulse", {31'd0, timeout_err}, 32'd1);
        check("to_err_cnt", {24'd0, err_cnt}, 32'd3);
        step();
        check("to_pulse_1cyc", {31'd0, timeout_err}, 32'd0);
        // 10^20^30^40 = 40
        send_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'h40, 1'b0);
        check("to_next_start", {31'd0, start_trs}, 32'd1);
        check("to_next_cmd", cmd, 32'h1020_3040);
        pulse_done();

        // Byte exactly in the expiry cycle wins
        drive(SYNC);
        drive(8'h02);
        repeat (TO - 1) step();
        drive(8'h00);
        @(negedge clk);
        check("to_late_byte", {31'd0, timeout_err}, 32'd0);
        rx_data  = 8'h12;
        rx_valid = 1'b1;
        drive(8'h34);
        drive(8'h24);
        step();
        check("late_start", {31'd0, start_trs}, 32'd1);
        check("late_cmd", cmd, 32'h0200_1234);
        check("late_err_cnt", {24'd0, err_cnt}, 32'd3);
        pulse_done();

        // Noise before sync, then SYNC-valued payload
        drive(8'h00); drive(8'hFF); drive(8'h13);
        send_frame(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 1'b0);
        check("noise_start", {31'd0, start_trs}, 32'd1);
        check("noise_cmd", cmd, 32'hA5A5_A5A5);
        check("noise_err_cnt", {24'd0, err_cnt}, 32'd3);

        // Reset mid-body while busy
        drive(SYNC); drive(8'h01); drive(8'h02);
        @(negedge clk);
        rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_cmd", cmd, 32'h0);
        check("mid_rst_busy", {31'd0, cmd_busy}, 32'd0);
        check("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("mid_rst_start", {31'd0, start_trs}, 32'd0);
        rst = 1'b0;
        drive(8'h03); drive(8'h04); drive(8'h05);
        step();
        check("post_rst_no_issue", {30'd0, start_trs, frame_err}, 32'd0);
        // 0A^0B^0C^0D = 00
        send_frame(8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h00, 1'b0);
        check("post_rst_start", {31'd0, start_trs}, 32'd1);
        check("post_rst_cmd", cmd, 32'h0A0B_0C0D);

        // Back-to-back bad frames, then saturation
        for (int i = 0; i < 10; i++) bad_frame();
        step();
        check("b2b_err_cnt", {24'd0, err_cnt}, 32'd10);
        for (int i = 0; i < 290; i++) bad_frame();
        step();
        check("sat_frame_err", {31'd0, frame_err}, 32'd1);
        check("sat_err_cnt", {24'd0, err_cnt}, 32'd255);
        check("sat_cmd", cmd, 32'h0A0B_0C0D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
